// File: rtl/mcu_io_pkg.sv
// Shared types and default port IDs for MCU I/O-port peripherals.
// Used by the fade ramp and any other port-mapped slave.
package mcu_io_pkg;

    typedef logic [7:0] level_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } fade_state_t;

    localparam logic [7:0] ADDR_LED_TARGET = 8'h40;
    localparam logic [7:0] ADDR_LED_RATE   = 8'h41;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every PRESCALE clocks.
// A synchronous clear restarts the count from zero.
module tick_gen #(
    parameter int PRESCALE = 50000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clear,
    output logic tick
);

    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clear || tick) cnt_d = '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rgb_fade_ramp.sv
// Per-channel brightness ramp: walks LED_LEVEL one LSB at a time
// toward an MCU-written target at a programmable tick rate.
module rgb_fade_ramp
    import mcu_io_pkg::*;
#(
    parameter logic [7:0] ADDR_TARGET = ADDR_LED_TARGET,
    parameter logic [7:0] ADDR_RATE   = ADDR_LED_RATE,
    parameter int         PRESCALE    = 50000,
    parameter logic [7:0] RATE_RESET  = 8'h10
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] LED_LEVEL,
    output logic       BUSY,
    output logic       DONE
);

    fade_state_t state_q, state_d;
    level_t      level_q, level_d;
    level_t      target_q, target_d;
    logic [7:0]  rate_q, rate_d;
    logic [7:0]  timer_q, timer_d;
    logic        done_q, done_d;
    logic        wr_tgt, wr_rate, tick;
    level_t      step_lvl;

    assign wr_tgt  = IO_STRB && (PORT_ID == ADDR_TARGET);
    assign wr_rate = IO_STRB && (PORT_ID == ADDR_RATE) && !wr_tgt;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clear (wr_tgt),
        .tick  (tick)
    );

    // State guarantees level is strictly on the correct side of target.
    assign step_lvl = (state_q == UP) ? level_q + 8'd1 : level_q - 8'd1;

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        rate_d   = rate_q;
        timer_d  = timer_q;
        done_d   = 1'b0;
        if (wr_tgt) begin
            target_d = OUT_PORT;
            timer_d  = '0;
            if (rate_q == 8'd0 || OUT_PORT == level_q) begin
                level_d = OUT_PORT;
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (OUT_PORT > level_q) begin
                state_d = UP;
            end else begin
                state_d = DOWN;
            end
        end else begin
            if (wr_rate) rate_d = OUT_PORT;
            if (state_q != IDLE && tick) begin
                if (rate_q == 8'd0) begin
                    level_d = target_q;
                    timer_d = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (timer_q >= rate_q - 8'd1) begin
                    timer_d = '0;
                    level_d = step_lvl;
                    if (step_lvl == target_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            level_q  <= '0;
            target_q <= '0;
            rate_q   <= RATE_RESET;
            timer_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            rate_q   <= rate_d;
            timer_q  <= timer_d;
            done_q   <= done_d;
        end
    end

    assign LED_LEVEL = level_q;
    assign BUSY      = (state_q != IDLE);
    assign DONE      = done_q;

endmodule

// File: tb/tb_rgb_fade_ramp.sv
// Directed bench for rgb_fade_ramp at PRESCALE=4.
module tb_rgb_fade_ramp;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] PORT_ID = '0;
    logic [7:0] OUT_PORT = '0;
    logic       IO_STRB = 1'b0;
    logic [7:0] LED_LEVEL;
    logic       BUSY;
    logic       DONE;

    int n_chk = 0;
    int n_pass = 0;

    localparam logic [7:0] TGT = 8'h40;
    localparam logic [7:0] RAT = 8'h41;

    rgb_fade_ramp #(.PRESCALE(4)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .PORT_ID   (PORT_ID),
        .OUT_PORT  (OUT_PORT),
        .IO_STRB   (IO_STRB),
        .LED_LEVEL (LED_LEVEL),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Strobe lands on one edge; returns 1 time unit after it.
    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        @(negedge CLK);
        PORT_ID  = id;
        OUT_PORT = d;
        IO_STRB  = 1'b1;
        @(posedge CLK);
        #1;
        IO_STRB  = 1'b0;
    endtask

    task automatic edges(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    task automatic st(input string tag, input int lvl, input int b, input int d);
        chk({tag, ".lvl"}, LED_LEVEL, lvl);
        chk({tag, ".busy"}, BUSY, b);
        chk({tag, ".done"}, DONE, d);
    endtask

    initial begin
        #2;
        st("rst0", 0, 0, 0);
        edges(2);
        RST_N = 1'b1;
        edges(1);

        // up ramp 0 -> 3 at rate 2
        wr(RAT, 8'd2);
        wr(TGT, 8'd3);
        st("up.N", 0, 1, 0);
        edges(7);  st("up.N7", 0, 1, 0);
        edges(1);  st("up.N8", 1, 1, 0);
        edges(8);  st("up.N16", 2, 1, 0);
        edges(7);  st("up.N23", 2, 1, 0);
        edges(1);  st("up.N24", 3, 0, 1);
        edges(1);  st("up.N25", 3, 0, 0);

        // down ramp 5 -> 2 at rate 1
        wr(RAT, 8'd0);
        wr(TGT, 8'd5);
        st("r0.5", 5, 0, 1);
        wr(RAT, 8'd1);
        wr(TGT, 8'd2);
        edges(4);  st("dn.N4", 4, 1, 0);
        edges(4);  st("dn.N8", 3, 1, 0);
        edges(4);  st("dn.N12", 2, 0, 1);
        edges(20); st("dn.hold", 2, 0, 0);

        // retarget 0 -> 10, flip to 1 at level 4
        wr(RAT, 8'd0);
        wr(TGT, 8'd0);
        wr(RAT, 8'd1);
        wr(TGT, 8'd10);
        edges(16); st("rt.lvl4", 4, 1, 0);
        wr(TGT, 8'd1);
        st("rt.M", 4, 1, 0);
        edges(4);  st("rt.M4", 3, 1, 0);
        edges(4);  st("rt.M8", 2, 1, 0);
        edges(4);  st("rt.M12", 1, 0, 1);
        edges(1);  st("rt.M13", 1, 0, 0);

        // rate 0 jump, then no-op write
        wr(RAT, 8'd0);
        wr(TGT, 8'd200);
        st("r0.200", 200, 0, 1);
        edges(1);  st("r0.after", 200, 0, 0);
        wr(TGT, 8'd200);
        st("noop", 200, 0, 1);
        edges(1);  st("noop.after", 200, 0, 0);

        // unmapped port ID
        wr(8'h42, 8'd7);
        st("dec", 200, 0, 0);
        edges(10); st("dec.hold", 200, 0, 0);

        // top and bottom edges
        wr(TGT, 8'd254);
        wr(RAT, 8'd1);
        wr(TGT, 8'd255);
        edges(4);  st("hi.N4", 255, 0, 1);
        edges(20); st("hi.hold", 255, 0, 0);
        wr(RAT, 8'd0);
        wr(TGT, 8'd1);
        wr(RAT, 8'd1);
        wr(TGT, 8'd0);
        edges(4);  st("lo.N4", 0, 0, 1);
        edges(20); st("lo.hold", 0, 0, 0);

        // rate dropped to 0 mid-ramp completes at next tick
        wr(RAT, 8'd4);
        wr(TGT, 8'd10);
        edges(5);
        wr(RAT, 8'd0);
        edges(1);  st("rz.N7", 0, 1, 0);
        edges(1);  st("rz.N8", 10, 0, 1);

        // async reset mid-ramp, then default rate 16
        wr(RAT, 8'd1);
        wr(TGT, 8'd100);
        edges(10);
        chk("pre_rst.lvl", LED_LEVEL, 12);
        RST_N = 1'b0;
        #1;
        st("rst.mid", 0, 0, 0);
        edges(1);
        RST_N = 1'b1;
        wr(TGT, 8'd1);
        edges(63); st("dflt.N63", 0, 1, 0);
        edges(1);  st("dflt.N64", 1, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
